// File: rtl/gpio_pad_ctrl_if.sv
// Peripheral bus between the core and gpio_pad_ctrl.
// Latency: n/a (signal bundle only).
// Backpressure: requester holds sel until ready pulses.
//
// Ports: sel/write/addr/wdata (requester -> controller),
//        rdata/ready/irq (controller -> requester).
interface gpio_pad_ctrl_if;
  logic        sel;
  logic        write;
  logic [2:0]  addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        ready;
  logic        irq;

  modport master (
    output sel, write, addr, wdata,
    input  rdata, ready, irq
  );

  modport slave (
    input  sel, write, addr, wdata,
    output rdata, ready, irq
  );
endinterface

// File: rtl/gpio_pad_ctrl.sv
// Register-mapped GPIO pad controller with sequenced turnaround and edge interrupts.
// Latency: bus access completes 1 cycle after sel; OE enables rise TURN cycles after that.
// Backpressure: OE writes are held off (ready withheld) while a turnaround is pending.
//
// Ports: clk, reset (async, active-low); bus (slave side of gpio_pad_ctrl_if);
//        gpio_read (pad p2c), gpio_write (pad c2p), gpio_writeEnable (pad c2p_en).
module gpio_pad_ctrl #(
  parameter int N_PINS      = 8,
  parameter int SYNC_STAGES = 2,
  parameter int TURN        = 2
) (
  input  logic                clk,
  input  logic                reset,
  gpio_pad_ctrl_if.slave      bus,
  input  logic [N_PINS-1:0]   gpio_read,
  output logic [N_PINS-1:0]   gpio_write,
  output logic [N_PINS-1:0]   gpio_writeEnable
);

  localparam int CW = $clog2(TURN + 1);

  localparam logic [2:0] A_OUT     = 3'd0;
  localparam logic [2:0] A_OE      = 3'd1;
  localparam logic [2:0] A_IN      = 3'd2;
  localparam logic [2:0] A_RISE_EN = 3'd3;
  localparam logic [2:0] A_FALL_EN = 3'd4;
  localparam logic [2:0] A_PEND    = 3'd5;
  localparam logic [2:0] A_OE_EFF  = 3'd6;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } dir_state_t;

  dir_state_t        state_q;
  logic [CW-1:0]     cnt_q;
  logic [N_PINS-1:0] up_q;
  logic [N_PINS-1:0] eff_q;

  logic [N_PINS-1:0] out_q;
  logic [N_PINS-1:0] oe_q;
  logic [N_PINS-1:0] rise_en_q;
  logic [N_PINS-1:0] fall_en_q;
  logic [N_PINS-1:0] pend_q;
  logic [N_PINS-1:0] sync_q [SYNC_STAGES];
  logic [N_PINS-1:0] dly_q;

  logic              ready_q;
  logic [31:0]       rdata_q;

  logic              oe_stall;
  logic              accept;
  logic              wr;
  logic              oe_wr;
  logic [N_PINS-1:0] wdat;
  logic [N_PINS-1:0] in_sync;
  logic [N_PINS-1:0] pend_set;
  logic [N_PINS-1:0] pend_clr;
  logic [31:0]       rd_val;
  logic              unused_wdata;

  function automatic logic [31:0] zext(input logic [N_PINS-1:0] v);
    logic [31:0] r;
    r = '0;
    r[N_PINS-1:0] = v;
    return r;
  endfunction

  // An OE write cannot start a new turnaround while one is in flight.
  // The !ready_q term keeps a still-held sel from being taken twice.
  assign oe_stall = bus.write && (bus.addr == A_OE) && (state_q == HOLD);
  assign accept   = bus.sel && !ready_q && !oe_stall;
  assign wr       = accept && bus.write;
  assign oe_wr    = wr && (bus.addr == A_OE);
  assign wdat     = bus.wdata[N_PINS-1:0];

  // Bits of wdata above N_PINS have no register behind them.
  assign unused_wdata = ^bus.wdata;

  assign in_sync  = sync_q[SYNC_STAGES-1];
  assign pend_set = (in_sync & ~dly_q & rise_en_q) | (~in_sync & dly_q & fall_en_q);
  assign pend_clr = (wr && (bus.addr == A_PEND)) ? wdat : '0;

  always_comb begin
    rd_val = '0;
    case (bus.addr)
      A_OUT:     rd_val = zext(out_q);
      A_OE:      rd_val = zext(oe_q);
      A_IN:      rd_val = zext(in_sync);
      A_RISE_EN: rd_val = zext(rise_en_q);
      A_FALL_EN: rd_val = zext(fall_en_q);
      A_PEND:    rd_val = zext(pend_q);
      A_OE_EFF:  rd_val = zext(eff_q);
      default:   rd_val = '0;
    endcase
  end

  // Bus response and plain registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ready_q   <= 1'b0;
      rdata_q   <= '0;
      out_q     <= '0;
      oe_q      <= '0;
      rise_en_q <= '0;
      fall_en_q <= '0;
      pend_q    <= '0;
    end else begin
      ready_q <= accept;
      rdata_q <= (accept && !bus.write) ? rd_val : '0;
      if (wr) begin
        case (bus.addr)
          A_OUT:     out_q     <= wdat;
          A_OE:      oe_q      <= wdat;
          A_RISE_EN: rise_en_q <= wdat;
          A_FALL_EN: fall_en_q <= wdat;
          default:   ;
        endcase
      end
      // Set is ORed in after the clear so a same-cycle edge is never lost.
      pend_q <= (pend_q & ~pend_clr) | pend_set;
    end
  end

  // Input synchronizer plus one delay stage for edge detection.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
      dly_q <= '0;
    end else begin
      sync_q[0] <= gpio_read;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      dly_q <= in_sync;
    end
  end

  // Direction sequencer: enables drop at once, rise only after TURN cycles.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      up_q    <= '0;
      eff_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (oe_wr) begin
            // eff & new == eff with the 'down' bits removed.
            eff_q <= eff_q & wdat;
            if (|(wdat & ~eff_q)) begin
              up_q    <= wdat & ~eff_q;
              cnt_q   <= CW'(TURN);
              state_q <= HOLD;
            end
          end
        end
        HOLD: begin
          // The edge that takes the counter to zero is the one that
          // releases the held enables, giving exactly TURN cycles of hold.
          if (cnt_q <= CW'(1)) begin
            eff_q   <= eff_q | up_q;
            up_q    <= '0;
            cnt_q   <= '0;
            state_q <= IDLE;
          end else begin
            cnt_q <= cnt_q - CW'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.ready        = ready_q;
  assign bus.rdata        = rdata_q;
  assign bus.irq          = |pend_q;
  assign gpio_write       = out_q;
  assign gpio_writeEnable = eff_q;

endmodule

// File: doc/gpio_pad_ctrl.md
# gpio_pad_ctrl

Register-mapped controller for the eight bidirectional GPIO pads (`sg13g2_IOPadInOut4mA`) in the padring. It owns the pads' `c2p`/`c2p_en` drive and synchronizes their `p2c` read-back. Direction changes are sequenced so a pad is never driven during a turnaround window. Synchronized inputs raise per-pin edge interrupts. It sits between the core peripheral bus and the `gpio_*` pad nets.

## Interface
- `N_PINS`, 8: number of pads controlled (1..32).
- `SYNC_STAGES`, 2: input synchronizer depth (≥2).
- `TURN`, 2: cycles an input→output transition is held off (≥1).

- `clk` in 1: core clock.
- `reset` in 1: asynchronous, active-low reset.
- `sel` in 1: bus request; held until `ready`.
- `write` in 1: 1 = write, 0 = read; stable while `sel`.
- `addr` in 3: word index.
- `wdata` in 32: write data; bits ≥ `N_PINS` ignored.
- `rdata` out 32: read data; valid when `ready`; zero otherwise.
- `ready` out 1: one-cycle completion pulse.
- `irq` out 1: OR of pending bits.
- `gpio_read` in `N_PINS`: pad `p2c`.
- `gpio_write` out `N_PINS`: pad `c2p`.
- `gpio_writeEnable` out `N_PINS`: pad `c2p_en`.

## Operation
- Register map (word index, access):
  - 0 OUT, rw: drive value.
  - 1 OE, rw: requested direction; reads return the requested value.
  - 2 IN, ro: synchronized input.
  - 3 RISE_EN, rw: rising-edge interrupt enable.
  - 4 FALL_EN, rw: falling-edge interrupt enable.
  - 5 PEND, w1c: interrupt pending.
  - 6 OE_EFF, ro: effective enable, equal to `gpio_writeEnable`.
  - 7 reserved: reads 0, writes ignored.
- `gpio_write` = OUT at all times. Read-back is independent of OE.
- Direction FSM, states IDLE and HOLD:
  - On an OE write in IDLE, compute `up` = new & ~eff and `down` = ~new & eff.
  - `down` bits clear in `gpio_writeEnable` immediately.
  - If `up` is nonzero, go to HOLD, load counter = `TURN`, and latch `up`.
  - In HOLD the counter decrements each cycle. At 0, OR the latched `up` into the effective enable and return to IDLE.
  - An OE write arriving in HOLD is stalled: `ready` is withheld until IDLE, then the write is processed as above.
  - All other accesses are never stalled, including in HOLD.
- Input path: `SYNC_STAGES` flops per pin, plus one delay flop for edge detection.
  - rise = sync & ~dly; fall = ~sync & dly.
  - PEND[i] sets on (rise & RISE_EN) | (fall & FALL_EN).
  - A W1C write clears a pending bit. If a set and a clear hit the same bit in the same cycle, set wins.
- Disabling an enable does not clear PEND.

## Timing
- Bus access: `sel` is sampled in cycle 0. `ready` and `rdata` appear in cycle 1, and `sel` must drop by cycle 2.
  - A write updates its register on the edge that raises `ready`; outputs reflect it in cycle 1.
  - Back-to-back accesses complete at most one per two cycles.
- OE write: `down` bits drop in cycle 1. `up` bits rise in cycle 1+`TURN`.
- Pin→IN visibility: `SYNC_STAGES` cycles. Pin edge→PEND/`irq`: `SYNC_STAGES`+1 cycles.
- `irq` is combinational from the PEND flops.
- Reset (async assert, sync-safe deassert assumed upstream):
  - All registers, synchronizer and delay flops clear to 0.
  - FSM goes to IDLE.
  - `gpio_write`, `gpio_writeEnable`, `rdata`, `ready` and `irq` are all 0.
  - Reset asserted mid-HOLD aborts the transition; no pending enable survives it.
- Since the enables are 0 out of reset, a pin that is high at reset deassertion does not set PEND.

## Test plan
- Reset, then read all 8 words → all 0. `gpio_writeEnable` = 0, `irq` = 0.
- Write OUT=0xA5, then OE=0x0F. Expect:
  - `gpio_write` = 0xA5 in cycle 1.
  - `gpio_writeEnable` = 0x00 during cycles 1–2 and 0x0F from cycle 3 (`TURN`=2).
  - OE_EFF reads 0x0F afterward.
- With OE_EFF=0x0F:
  - Write OE=0xF0 → bits 3:0 drop in cycle 1 and bits 7:4 rise in cycle 3.
  - A second OE write issued in cycle 2 gets `ready` only after the FSM returns to IDLE.
- RISE_EN=0x01, FALL_EN=0x02:
  - Toggle pin0 0→1 → PEND=0x01 and `irq`=1 exactly 3 cycles after the edge.
  - Drive pin1 1→0 → PEND=0x03.
  - A rising edge on pin1 leaves PEND unchanged.
- W1C PEND with 0x01 in the same cycle as a new pin0 rising detection → PEND bit0 stays 1.
  - A later write of 0x03 with no new edges → PEND=0, `irq`=0.
- Assert `reset` during HOLD, then release → `gpio_writeEnable` stays 0, OE=0, and the FSM is in IDLE.
